// File: rtl/axi_rd_mux_wrr.sv
// rtl/axi_rd_mux_wrr.sv - N-to-1 AXI4 read mux with ID extension, round-robin/WRR arbitration and per-port outstanding limits.
// Optional macro AXI_RD_MUX_WRR_EN adds weight_i and weighted round-robin credit tracking.
module axi_rd_mux_wrr #(
    parameter int NoSlvPorts  = 4,
    parameter int IdWidth     = 4,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 64,
    parameter int MaxTrans    = 8,
    parameter int WeightWidth = 4,
    parameter int PortIdxW    = (NoSlvPorts == 1) ? 1 : $clog2(NoSlvPorts)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NoSlvPorts-1:0]           slv_ar_valid_i,
    output logic [NoSlvPorts-1:0]           slv_ar_ready_o,
    input  logic [NoSlvPorts*IdWidth-1:0]   slv_ar_id_i,
    input  logic [NoSlvPorts*AddrWidth-1:0] slv_ar_addr_i,
    input  logic [NoSlvPorts*8-1:0]         slv_ar_len_i,
    output logic [NoSlvPorts-1:0]           slv_r_valid_o,
    input  logic [NoSlvPorts-1:0]           slv_r_ready_i,
    output logic [IdWidth-1:0]              slv_r_id_o,
    output logic [DataWidth-1:0]            slv_r_data_o,
    output logic [1:0]                      slv_r_resp_o,
    output logic                            slv_r_last_o,
    output logic                            mst_ar_valid_o,
    input  logic                            mst_ar_ready_i,
    output logic [IdWidth+PortIdxW-1:0]     mst_ar_id_o,
    output logic [AddrWidth-1:0]            mst_ar_addr_o,
    output logic [7:0]                      mst_ar_len_o,
    input  logic                            mst_r_valid_i,
    output logic                            mst_r_ready_o,
    input  logic [IdWidth+PortIdxW-1:0]     mst_r_id_i,
    input  logic [DataWidth-1:0]            mst_r_data_i,
    input  logic [1:0]                      mst_r_resp_i,
    input  logic                            mst_r_last_i,
`ifdef AXI_RD_MUX_WRR_EN
    input  logic [NoSlvPorts*WeightWidth-1:0] weight_i,
`endif
    output logic                            r_route_err_o,
    output logic                            busy_o
);
    localparam int CntW = $clog2(MaxTrans + 1);

    logic [CntW-1:0]       cnt [NoSlvPorts];
    logic [NoSlvPorts-1:0] elig;
    logic [NoSlvPorts-1:0] dec;
    logic [PortIdxW-1:0]   ptr;
    logic [PortIdxW-1:0]   cand;
    logic [PortIdxW-1:0]   cand_next;
    logic                  cand_valid;
    logic                  load;
    logic [PortIdxW-1:0]   r_port;
    logic                  r_port_ok;

    always_comb begin
        for (int i = 0; i < NoSlvPorts; i++) begin
            elig[i] = slv_ar_valid_i[i] && (cnt[i] < CntW'(MaxTrans));
        end
    end

    // Scan downward so the eligible port closest to ptr is the last one written.
    always_comb begin
        int idx;
        cand       = '0;
        cand_valid = 1'b0;
        for (int k = NoSlvPorts - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NoSlvPorts) idx = idx - NoSlvPorts;
            if (elig[idx]) begin
                cand       = PortIdxW'(idx);
                cand_valid = 1'b1;
            end
        end
    end

    assign cand_next = (cand == PortIdxW'(NoSlvPorts - 1)) ? '0 : cand + 1'b1;
    assign load      = cand_valid && (!mst_ar_valid_o || mst_ar_ready_i);

    always_comb begin
        for (int i = 0; i < NoSlvPorts; i++) begin
            slv_ar_ready_o[i] = load && (cand == PortIdxW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mst_ar_valid_o <= 1'b0;
            mst_ar_id_o    <= '0;
            mst_ar_addr_o  <= '0;
            mst_ar_len_o   <= '0;
        end else if (load) begin
            mst_ar_valid_o <= 1'b1;
            mst_ar_id_o    <= {cand, slv_ar_id_i[int'(cand)*IdWidth +: IdWidth]};
            mst_ar_addr_o  <= slv_ar_addr_i[int'(cand)*AddrWidth +: AddrWidth];
            mst_ar_len_o   <= slv_ar_len_i[int'(cand)*8 +: 8];
        end else if (mst_ar_ready_i) begin
            mst_ar_valid_o <= 1'b0;
        end
    end

`ifdef AXI_RD_MUX_WRR_EN
    logic [WeightWidth-1:0] credit;
    logic [WeightWidth-1:0] eff_w;
    logic [WeightWidth-1:0] rem;

    always_comb begin
        eff_w = weight_i[int'(cand)*WeightWidth +: WeightWidth];
        if (eff_w == '0) eff_w = WeightWidth'(1);
        rem = (cand == ptr && credit != '0) ? credit : eff_w;
    end

    // Credit holds the grants the current port may still take before ptr moves on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr    <= '0;
            credit <= '0;
        end else if (load) begin
            if (rem == WeightWidth'(1)) begin
                ptr    <= cand_next;
                credit <= '0;
            end else begin
                ptr    <= cand;
                credit <= rem - 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= cand_next;
        end
    end
`endif

    assign r_port    = mst_r_id_i[IdWidth +: PortIdxW];
    assign r_port_ok = int'(r_port) < NoSlvPorts;

    assign slv_r_id_o    = mst_r_id_i[IdWidth-1:0];
    assign slv_r_data_o  = mst_r_data_i;
    assign slv_r_resp_o  = mst_r_resp_i;
    assign slv_r_last_o  = mst_r_last_i;
    // Beats with a bad port field are sunk so the master never stalls on them.
    assign mst_r_ready_o = r_port_ok ? slv_r_ready_i[r_port] : 1'b1;

    always_comb begin
        for (int i = 0; i < NoSlvPorts; i++) begin
            slv_r_valid_o[i] = mst_r_valid_i && r_port_ok && (r_port == PortIdxW'(i));
            dec[i]           = slv_r_valid_o[i] && slv_r_ready_i[i] && mst_r_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_route_err_o <= 1'b0;
        end else if (mst_r_valid_i && !r_port_ok) begin
            r_route_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NoSlvPorts; i++) begin
            if (rst_i) begin
                cnt[i] <= '0;
            end else if (slv_ar_ready_o[i] && !dec[i] && cnt[i] != CntW'(MaxTrans)) begin
                cnt[i] <= cnt[i] + 1'b1;
            end else if (dec[i] && !slv_ar_ready_o[i] && cnt[i] != '0) begin
                cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy_o = mst_ar_valid_o;
        for (int i = 0; i < NoSlvPorts; i++) begin
            if (cnt[i] != '0) busy_o = 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_rd_mux_wrr.sv
// tb/tb_axi_rd_mux_wrr.sv - directed self-checking bench for axi_rd_mux_wrr (3 ports, MaxTrans=2).
module tb_axi_rd_mux_wrr;
    localparam int N  = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ar_valid;
    logic [N-1:0]    ar_ready;
    logic [N*IW-1:0] ar_id;
    logic [N*AW-1:0] ar_addr;
    logic [N*8-1:0]  ar_len;
    logic [N-1:0]    r_valid;
    logic [N-1:0]    r_ready;
    logic [IW-1:0]   r_id;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic            m_ar_valid;
    logic            m_ar_ready;
    logic [IW+PW-1:0] m_ar_id;
    logic [AW-1:0]   m_ar_addr;
    logic [7:0]      m_ar_len;
    logic            m_r_valid;
    logic            m_r_ready;
    logic [IW+PW-1:0] m_r_id;
    logic [DW-1:0]   m_r_data;
    logic [1:0]      m_r_resp;
    logic            m_r_last;
    logic [N*4-1:0]  weight;
    logic            route_err;
    logic            busy;

    int total = 0;
    int bad   = 0;

    axi_rd_mux_wrr #(
        .NoSlvPorts(N), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW),
        .MaxTrans(2), .WeightWidth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready),
        .slv_ar_id_i(ar_id), .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len),
        .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready),
        .slv_r_id_o(r_id), .slv_r_data_o(r_data), .slv_r_resp_o(r_resp), .slv_r_last_o(r_last),
        .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready),
        .mst_ar_id_o(m_ar_id), .mst_ar_addr_o(m_ar_addr), .mst_ar_len_o(m_ar_len),
        .mst_r_valid_i(m_r_valid), .mst_r_ready_o(m_r_ready), .mst_r_id_i(m_r_id),
        .mst_r_data_i(m_r_data), .mst_r_resp_i(m_r_resp), .mst_r_last_i(m_r_last),
`ifdef AXI_RD_MUX_WRR_EN
        .weight_i(weight),
`endif
        .r_route_err_o(route_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ar_valid = '0; m_ar_ready = 1'b1; m_r_valid = 1'b0; r_ready = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        ar_id = '0; ar_addr = '0; ar_len = '0; weight = '0;
        m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;
        do_reset();
        #1;
        total++; if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL reset_ar_valid got=%b exp=0", m_ar_valid); end
        total++; if (route_err !== 1'b0) begin bad++; $display("FAIL reset_route_err got=%b exp=0", route_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (ar_ready !== 3'b000) begin bad++; $display("FAIL reset_ar_ready got=%b exp=000", ar_ready); end
    endtask

    task automatic test_single;
        do_reset();
        ar_valid = 3'b010; ar_id[IW +: IW] = 4'd3; ar_addr[AW +: AW] = 32'h1000; ar_len[8 +: 8] = 8'd0;
        #1;
        total++; if (ar_ready !== 3'b010) begin bad++; $display("FAIL single_ar_ready got=%b exp=010", ar_ready); end
        tick();
        ar_valid = '0;
        total++; if (m_ar_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid got=%b exp=1", m_ar_valid); end
        total++; if (m_ar_id !== 6'b01_0011) begin bad++; $display("FAIL single_m_id got=%b exp=010011", m_ar_id); end
        total++; if (m_ar_addr !== 32'h1000 || m_ar_len !== 8'd0) begin bad++; $display("FAIL single_m_addr got=%h/%0d exp=1000/0", m_ar_addr, m_ar_len); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_on got=%b exp=1", busy); end
        tick();
        total++; if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", m_ar_valid); end
        m_r_valid = 1'b1; m_r_id = 6'b01_0011; m_r_last = 1'b1; m_r_data = 64'hDEAD; m_r_resp = 2'b00; r_ready = 3'b010;
        #1;
        total++; if (r_valid !== 3'b010) begin bad++; $display("FAIL single_r_valid got=%b exp=010", r_valid); end
        total++; if (r_id !== 4'd3 || r_data !== 64'hDEAD || r_last !== 1'b1) begin bad++; $display("FAIL single_r_payload got=%h/%h/%b exp=3/dead/1", r_id, r_data, r_last); end
        total++; if (m_r_ready !== 1'b1) begin bad++; $display("FAIL single_m_r_ready got=%b exp=1", m_r_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_pending got=%b exp=1", busy); end
        tick();
        m_r_valid = 1'b0; m_r_last = 1'b0; r_ready = '0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_off got=%b exp=0", busy); end
    endtask

    task automatic test_rr;
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        logic [2:0] exp_rdy;
        do_reset();
        ar_valid = 3'b111; m_ar_ready = 1'b1;
        for (int k = 0; k < 3; k++) ar_id[k*IW +: IW] = 4'(k + 8);
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 3'b001 << exp_order[c];
            total++; if (ar_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", c, ar_ready, exp_rdy); end
            tick();
            total++; if (m_ar_id !== {2'(exp_order[c]), 4'(exp_order[c] + 8)}) begin bad++; $display("FAIL rr_mid%0d got=%b", c, m_ar_id); end
        end
        #1;
        total++; if (ar_ready !== 3'b000) begin bad++; $display("FAIL rr_all_full got=%b exp=000", ar_ready); end
        ar_valid = '0;
    endtask

`ifdef AXI_RD_MUX_WRR_EN
    task automatic test_wrr;
        int exp_order [10] = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        logic [2:0] exp_rdy;
        do_reset();
        weight = {4'd0, 4'd1, 4'd3};
        ar_valid = 3'b111; m_ar_ready = 1'b1; r_ready = 3'b111; m_r_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                m_r_valid = 1'b1;
                m_r_id = {2'(exp_order[c-1]), 4'd0};
            end
            #1;
            exp_rdy = 3'b001 << exp_order[c];
            total++; if (ar_ready !== exp_rdy) begin bad++; $display("FAIL wrr_grant%0d got=%b exp=%b", c, ar_ready, exp_rdy); end
            tick();
        end
        ar_valid = '0; m_r_valid = 1'b0; m_r_last = 1'b0; r_ready = '0;
    endtask
`endif

    task automatic test_limit;
        do_reset();
        ar_valid = 3'b001; m_ar_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (ar_ready !== 3'b001) begin bad++; $display("FAIL limit_acc%0d got=%b exp=001", c, ar_ready); end
            tick();
        end
        ar_valid = 3'b101;
        #1;
        total++; if (ar_ready !== 3'b100) begin bad++; $display("FAIL limit_block got=%b exp=100", ar_ready); end
        tick();
        ar_valid = 3'b001;
        m_r_valid = 1'b1; m_r_id = {2'd0, 4'd0}; m_r_last = 1'b1; r_ready = 3'b001;
        #1;
        total++; if (ar_ready !== 3'b000) begin bad++; $display("FAIL limit_still got=%b exp=000", ar_ready); end
        total++; if (r_valid !== 3'b001) begin bad++; $display("FAIL limit_r_valid got=%b exp=001", r_valid); end
        tick();
        m_r_valid = 1'b0; m_r_last = 1'b0; r_ready = '0;
        #1;
        total++; if (ar_ready !== 3'b001) begin bad++; $display("FAIL limit_reopen got=%b exp=001", ar_ready); end
        tick();
        ar_valid = '0;
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        do_reset();
        ar_id[0 +: IW] = 4'd5; ar_addr[0 +: AW] = 32'h2000;
        ar_id[IW +: IW] = 4'd6; ar_addr[AW +: AW] = 32'h3000;
        ar_valid = 3'b011; m_ar_ready = 1'b0;
        #1;
        accepts += $countones(ar_ready & ar_valid);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            accepts += $countones(ar_ready & ar_valid);
            total++; if (m_ar_valid !== 1'b1 || m_ar_id !== 6'b00_0101 || m_ar_addr !== 32'h2000) begin
                bad++; $display("FAIL bp_stable%0d got=%b/%b/%h exp=1/000101/2000", c, m_ar_valid, m_ar_id, m_ar_addr);
            end
            tick();
        end
        total++; if (accepts !== 1) begin bad++; $display("FAIL bp_accepts got=%0d exp=1", accepts); end
        m_ar_ready = 1'b1;
        #1;
        total++; if (ar_ready !== 3'b010) begin bad++; $display("FAIL bp_release got=%b exp=010", ar_ready); end
        tick();
        ar_valid = '0;
        total++; if (m_ar_valid !== 1'b1 || m_ar_id !== 6'b01_0110 || m_ar_addr !== 32'h3000) begin
            bad++; $display("FAIL bp_next got=%b/%b/%h exp=1/010110/3000", m_ar_valid, m_ar_id, m_ar_addr);
        end
    endtask

    task automatic test_route_err;
        do_reset();
        m_r_valid = 1'b1; m_r_id = {2'd3, 4'd1}; m_r_last = 1'b1; r_ready = 3'b000;
        #1;
        total++; if (m_r_ready !== 1'b1) begin bad++; $display("FAIL rerr_ready got=%b exp=1", m_r_ready); end
        total++; if (r_valid !== 3'b000) begin bad++; $display("FAIL rerr_valid got=%b exp=000", r_valid); end
        tick();
        m_r_valid = 1'b0; m_r_last = 1'b0;
        tick();
        total++; if (route_err !== 1'b1) begin bad++; $display("FAIL rerr_sticky got=%b exp=1", route_err); end
        ar_valid = 3'b001; ar_id[0 +: IW] = 4'd2;
        tick();
        total++; if (busy !== 1'b1 || m_ar_valid !== 1'b1) begin bad++; $display("FAIL rerr_midburst got=%b/%b exp=1/1", busy, m_ar_valid); end
        rst = 1'b1; ar_valid = '0;
        tick();
        rst = 1'b0;
        total++; if (route_err !== 1'b0) begin bad++; $display("FAIL rst_route_err got=%b exp=0", route_err); end
        total++; if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL rst_ar_valid got=%b exp=0", m_ar_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_counters got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_rr();
`ifdef AXI_RD_MUX_WRR_EN
        test_wrr();
`endif
        test_limit();
        test_back_to_back();
        test_route_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
